// File: rtl/multiplier.sv
// multiplier: iterative 64x64 shift-add multiplier with selectable signed/unsigned high word
module multiplier #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op_signed,
  input  logic [WIDTH-1:0] mcand,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] prod,
  output logic [WIDTH-1:0] prod_hi,
  output logic             busy,
  output logic             done
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state;
  logic [2*WIDTH-1:0] acc, msh, acc_nx;
  logic [WIDTH-1:0] mc, mb, bsh, hi_fix;
  logic sgn;
  logic [CW-1:0] cnt;
  always_comb begin
    acc_nx = acc + (bsh[0] ? msh : '0);
    hi_fix = acc_nx[2*WIDTH-1:WIDTH] - (mc[WIDTH-1] ? mb : '0) - (mb[WIDTH-1] ? mc : '0);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      acc     <= '0;
      msh     <= '0;
      bsh     <= '0;
      mc      <= '0;
      mb      <= '0;
      sgn     <= 1'b0;
      cnt     <= '0;
      prod    <= '0;
      prod_hi <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          mc    <= mcand;
          mb    <= b;
          sgn   <= op_signed;
          msh   <= {{WIDTH{1'b0}}, mcand};
          bsh   <= b;
          acc   <= '0;
          cnt   <= '0;
          busy  <= 1'b1;
          state <= CALC;
        end
        CALC: begin
          acc <= acc_nx;
          msh <= msh << 1;
          bsh <= bsh >> 1;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            prod    <= acc_nx[WIDTH-1:0];
            prod_hi <= sgn ? hi_fix : acc_nx[2*WIDTH-1:WIDTH];
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_multiplier.sv
// tb_multiplier: scoreboard-based bench for the sequential multiplier
`timescale 1ns/1ps
module tb_multiplier;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic op_signed = 1'b0;
  logic [63:0] mcand = '0;
  logic [63:0] b = '0;
  logic [63:0] prod, prod_hi;
  logic busy, done;
  int checks = 0;
  int failures = 0;
  logic [127:0] sb_q[$];
  logic done_q = 1'b0;

  multiplier dut (
    .clk(clk), .reset(reset), .start(start), .op_signed(op_signed),
    .mcand(mcand), .b(b), .prod(prod), .prod_hi(prod_hi), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done === 1'b1) begin
      checks++;
      if (busy !== 1'b0) begin
        failures++;
        $display("FAIL busy_with_done busy=%b required 0", busy);
      end
      checks++;
      if (done_q === 1'b1) begin
        failures++;
        $display("FAIL done_pulse done high for 2+ cycles, required single cycle");
      end
    end
    done_q = done;
  end

  function automatic logic [127:0] ref_mul(input logic [63:0] x, input logic [63:0] y, input logic s);
    logic [127:0] xe, ye;
    xe = s ? {{64{x[63]}}, x} : {64'b0, x};
    ye = s ? {{64{y[63]}}, y} : {64'b0, y};
    return xe * ye;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [63:0] x, input logic [63:0] y, input logic s);
    mcand = x;
    b = y;
    op_signed = s;
    start = 1'b1;
    tick();
    start = 1'b0;
    mcand = {$urandom, $urandom};
    b = {$urandom, $urandom};
    op_signed = ~s;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    checks++;
    if (prod !== 64'h0) begin failures++; $display("FAIL reset_prod got %h required 0", prod); end
    checks++;
    if (prod_hi !== 64'h0) begin failures++; $display("FAIL reset_prod_hi got %h required 0", prod_hi); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b required 0", busy); end
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL reset_done got %b required 0", done); end
  endtask

  typedef struct {
    logic [63:0] x;
    logic [63:0] y;
    logic        s;
    logic [63:0] lo;
    logic [63:0] hi;
  } vec_t;

  task automatic test_vectors();
    vec_t v[8];
    logic [127:0] e;
    int n;
    v[0] = '{64'h8000000000000000, 64'h7FFFFFFFFFFFFFFF, 1'b1, 64'h8000000000000000, 64'hC000000000000000};
    v[1] = '{64'h8000000000000000, 64'h7FFFFFFFFFFFFFFF, 1'b0, 64'h8000000000000000, 64'h3FFFFFFFFFFFFFFF};
    v[2] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0, 64'h0000000000000001, 64'hFFFFFFFFFFFFFFFE};
    v[3] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b1, 64'h0000000000000001, 64'h0000000000000000};
    v[4] = '{64'h8000000000000000, 64'h8000000000000000, 1'b0, 64'h0, 64'h4000000000000000};
    v[5] = '{64'h8000000000000000, 64'h8000000000000000, 1'b1, 64'h0, 64'h4000000000000000};
    v[6] = '{64'h3, 64'hFFFFFFFFFFFFFFFB, 1'b1, 64'hFFFFFFFFFFFFFFF1, 64'hFFFFFFFFFFFFFFFF};
    v[7] = '{64'h3, 64'hFFFFFFFFFFFFFFFB, 1'b0, 64'hFFFFFFFFFFFFFFF1, 64'h0000000000000002};
    for (int i = 0; i < 8; i++) begin
      sb_q.push_back({v[i].hi, v[i].lo});
      issue(v[i].x, v[i].y, v[i].s);
      wait_done(n);
      checks++;
      if (n !== 64) begin failures++; $display("FAIL vec%0d_latency got %0d required 64", i, n); end
      e = sb_q.pop_front();
      checks++;
      if ({prod_hi, prod} !== e) begin
        failures++;
        $display("FAIL vec%0d_product got %h_%h required %h_%h", i, prod_hi, prod, e[127:64], e[63:0]);
      end
      tick();
    end
  endtask

  task automatic test_restart_ignored();
    logic [127:0] e;
    int n;
    sb_q.push_back(ref_mul(64'h123456789ABCDEF0, 64'hFEDCBA9876543210, 1'b1));
    issue(64'h123456789ABCDEF0, 64'hFEDCBA9876543210, 1'b1);
    for (int c = 1; c <= 9; c++) tick();
    mcand = 64'h5555AAAA5555AAAA;
    b = 64'h0F0F0F0F0F0F0F0F;
    op_signed = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(n);
    checks++;
    if (n + 10 !== 64) begin failures++; $display("FAIL restart_latency got %0d required 64", n + 10); end
    e = sb_q.pop_front();
    checks++;
    if ({prod_hi, prod} !== e) begin
      failures++;
      $display("FAIL restart_product got %h_%h required %h_%h", prod_hi, prod, e[127:64], e[63:0]);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL start_in_done busy=%b required 0", busy); end
    checks++;
    if ({prod_hi, prod} !== e) begin failures++; $display("FAIL result_hold got %h_%h required %h_%h", prod_hi, prod, e[127:64], e[63:0]); end
  endtask

  task automatic test_reset_abort();
    int seen;
    issue(64'hDEADBEEFCAFEF00D, 64'h0123456789ABCDEF, 1'b0);
    for (int c = 1; c <= 29; c++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got %b required 0", busy); end
    checks++;
    if (prod !== 64'h0) begin failures++; $display("FAIL abort_prod got %h required 0", prod); end
    checks++;
    if (prod_hi !== 64'h0) begin failures++; $display("FAIL abort_prod_hi got %h required 0", prod_hi); end
    seen = 0;
    for (int c = 0; c < 80; c++) begin
      if (done === 1'b1 || busy === 1'b1) seen++;
      tick();
    end
    checks++;
    if (seen !== 0) begin failures++; $display("FAIL abort_no_done activity cycles=%0d required 0", seen); end
  endtask

  task automatic test_random();
    logic [63:0] x, y;
    logic [127:0] e;
    int n;
    for (int i = 0; i < 350; i++) begin
      for (int s = 0; s < 2; s++) begin
        x = {$urandom, $urandom};
        y = {$urandom, $urandom};
        if ($urandom_range(0, 7) == 0) x = {$urandom_range(0, 1) ? 32'hFFFFFFFF : 32'h80000000, 32'h0} | 64'($urandom_range(0, 3));
        if ($urandom_range(0, 7) == 0) y = $urandom_range(0, 1) ? 64'hFFFFFFFFFFFFFFFF : 64'h8000000000000000;
        sb_q.push_back(ref_mul(x, y, s[0]));
        issue(x, y, s[0]);
        wait_done(n);
        checks++;
        if (n !== 64) begin failures++; $display("FAIL rand%0d_latency got %0d required 64", i, n); end
        e = sb_q.pop_front();
        checks++;
        if ({prod_hi, prod} !== e) begin
          failures++;
          $display("FAIL rand%0d_s%0d a=%h b=%h got %h_%h required %h_%h", i, s, x, y, prod_hi, prod, e[127:64], e[63:0]);
        end
        tick();
      end
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_restart_ignored();
    test_reset_abort();
    test_random();
    checks++;
    if (sb_q.size() !== 0) begin failures++; $display("FAIL scoreboard_leftover entries=%0d required 0", sb_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
